// File: rtl/apb_requester.sv
// APB3 requester: turns a valid/ready command into one APB transfer at a time
// and reports completion, slave error or timeout on a one-cycle response strobe.
module apb_requester #(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [SIZE-1:0] cmd_addr,
  input  logic [SIZE-1:0] cmd_wdata,
  output logic            rsp_valid,
  output logic [SIZE-1:0] rsp_rdata,
  output logic            rsp_error,
  output logic            rsp_timeout,
  output logic [SIZE-1:0] paddr,
  output logic [SIZE-1:0] pwdata,
  output logic            psel,
  output logic            penable,
  output logic            pwrite,
  input  logic [SIZE-1:0] prdata,
  input  logic            pready,
  input  logic            pslverr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_wait;
  logic            w_accept;
  logic            w_done;
  logic            w_abort;

  logic            r_psel;
  logic            r_penable;
  logic            r_pwrite;
  logic [SIZE-1:0] r_paddr;
  logic [SIZE-1:0] r_pwdata;
  logic            r_rsp_valid;
  logic [SIZE-1:0] r_rsp_rdata;
  logic            r_rsp_error;
  logic            r_rsp_timeout;

  // Held low during reset so no command slips in while the bus is recovering.
  assign cmd_ready = (r_state == S_IDLE) && !preset;

  always_ff @(posedge pclk) begin
    if (preset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    w_abort  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          w_accept = 1'b1;
          w_next   = S_SETUP;
        end
      end
      S_SETUP: w_next = S_ACCESS;
      S_ACCESS: begin
        if (pready) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end else if (TO_EN && (r_wait == TO_LAST)) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_wait        <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_psel      <= (w_next != S_IDLE);
      r_penable   <= (w_next == S_ACCESS);
      r_rsp_valid <= w_done || w_abort;
      if (w_accept) begin
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        if (cmd_write) r_pwdata <= cmd_wdata;
      end
      if (r_state == S_SETUP) begin
        r_wait <= '0;
      end else if (r_state == S_ACCESS && !pready && r_wait != 16'hffff) begin
        r_wait <= r_wait + 16'd1;
      end
      if (w_done) begin
        r_rsp_rdata   <= r_pwrite ? '0 : prdata;
        r_rsp_error   <= pslverr;
        r_rsp_timeout <= 1'b0;
      end else if (w_abort) begin
        r_rsp_rdata   <= '0;
        r_rsp_error   <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end
    end
  end

  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_error   = r_rsp_error;
  assign rsp_timeout = r_rsp_timeout;

endmodule
